// File: rtl/clt_gauss_pkg.sv
// -----------------------------------------------------------------------------
// clt_gauss_pkg
// Shared definitions for the central-limit Gaussian accumulator:
//   - state_e      : FSM state encoding (IDLE, ACC, OUT)
//   - UW_DEF       : default number of upper uniform bits used per word
//   - LOG2_N_DEF   : default log2 of uniforms summed per output sample
//   - gauss_offset : mean removal for an unsigned sum whose mean is 2**(ow-1)
// -----------------------------------------------------------------------------
package clt_gauss_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  localparam int UW_DEF     = 16;
  localparam int LOG2_N_DEF = 2;

  // Subtracting 2**(ow-1) from an ow-bit unsigned value is the same as
  // inverting its MSB and reading the result as two's complement.
  // Only the low ow bits of the result are meaningful.
  function automatic logic [63:0] gauss_offset(input logic [63:0] acc,
                                               input int unsigned ow);
    logic [63:0] msb_mask;
    msb_mask = 64'd1 << (ow - 32'd1);
    return acc ^ msb_mask;
  endfunction

endpackage

// File: rtl/clt_gauss_acc.sv
// -----------------------------------------------------------------------------
// clt_gauss_acc
// Produces approximately normal samples by summing NSAMP = 2**LOG2_N uniform
// values taken from an upstream Tausworthe generator, then removing the mean.
//
// Ports:
//   clk        in   1       clock
//   reset      in   1       asynchronous, active-high reset
//   en         in   1       start/continue generation
//   uni_req    out  1       advance request to the generator (rand_gen)
//   uni_data   in   32      uniform word from the generator (random_num)
//   uni_valid  in   1       generator word valid (rand_valid)
//   g_data     out  OW      signed normal sample, OW = UW + LOG2_N
//   g_valid    out  1       g_data valid
//   g_ready    in   1       consumer accepts g_data
//   busy       out  1       high while accumulating or presenting a sample
//   stat_cnt   out  32      (only with CLT_GAUSS_STATS_EN) count of
//                           g_valid & g_ready handshakes, wraps to 0
//
// Optional build macro: CLT_GAUSS_STATS_EN adds the stat_cnt port/counter.
// -----------------------------------------------------------------------------
module clt_gauss_acc
  import clt_gauss_pkg::*;
#(
  parameter  int UW     = UW_DEF,
  parameter  int LOG2_N = LOG2_N_DEF,
  localparam int OW     = UW + LOG2_N
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          uni_req,
  input  logic [31:0]   uni_data,
  input  logic          uni_valid,
  output logic [OW-1:0] g_data,
  output logic          g_valid,
  input  logic          g_ready,
  output logic          busy
`ifdef CLT_GAUSS_STATS_EN
  ,
  output logic [31:0]   stat_cnt
`endif
);

  // Counter needs at least one bit even when a single uniform is summed.
  localparam int CW = (LOG2_N > 0) ? LOG2_N : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_N) - 1);

  state_e        state_q, state_d;
  logic [OW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] g_data_q, g_data_d;
  logic          g_valid_q, g_valid_d;
  logic          uni_req_q, uni_req_d;
  logic          busy_q, busy_d;

  logic [UW-1:0] uni_word_s;
  logic          accept_s;
  logic [OW-1:0] acc_sum_s;
  logic [63:0]   off_full_s;
  logic          unused_off_s;

  // The generator word is sampled before it advances, so the value present
  // on the accepting edge is the one that belongs to this request.
  assign uni_word_s   = uni_data[31 -: UW];
  assign accept_s     = uni_req_q & uni_valid;
  assign acc_sum_s    = acc_q + OW'(uni_word_s);
  assign off_full_s   = gauss_offset(64'(acc_sum_s), OW);
  assign unused_off_s = ^off_full_s[63:OW];

  generate
    if (UW < 32) begin : g_unused_low
      logic unused_low_s;
      assign unused_low_s = ^uni_data[31-UW:0];
    end
  endgenerate

  // Next-state, accumulator and output-register logic.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    g_data_d  = g_data_q;
    g_valid_d = g_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_ACC;
          acc_d   = {OW{1'b0}};
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end

      // en is deliberately ignored here: a started sum always completes.
      ST_ACC: begin
        if (accept_s) begin
          acc_d = acc_sum_s;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d   = ST_OUT;
            g_valid_d = 1'b1;
            g_data_d  = off_full_s[OW-1:0];
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = ST_ACC;
        end
      end

      ST_OUT: begin
        if (g_ready) begin
          g_valid_d = 1'b0;
          if (en) begin
            state_d = ST_ACC;
            acc_d   = {OW{1'b0}};
            cnt_d   = {CW{1'b0}};
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_OUT;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        g_valid_d = 1'b0;
      end
    endcase

    // Request and busy follow the next state so they are registered outputs.
    uni_req_d = (state_d == ST_ACC);
    busy_d    = (state_d != ST_IDLE);
  end

  // State and datapath registers; reset discards any partial sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      acc_q     <= {OW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      g_data_q  <= {OW{1'b0}};
      g_valid_q <= 1'b0;
      uni_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      g_data_q  <= g_data_d;
      g_valid_q <= g_valid_d;
      uni_req_q <= uni_req_d;
      busy_q    <= busy_d;
    end
  end

  assign uni_req = uni_req_q;
  assign g_data  = g_data_q;
  assign g_valid = g_valid_q;
  assign busy    = busy_q;

`ifdef CLT_GAUSS_STATS_EN
  logic [31:0] stat_cnt_q, stat_cnt_d;

  // Handshake counter next value; wraps naturally at 32 bits.
  always_comb begin
    if (g_valid_q && g_ready) begin
      stat_cnt_d = stat_cnt_q + 32'd1;
    end else begin
      stat_cnt_d = stat_cnt_q;
    end
  end

  // Handshake counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_cnt_q <= 32'd0;
    end else begin
      stat_cnt_q <= stat_cnt_d;
    end
  end

  assign stat_cnt = stat_cnt_q;
`endif

endmodule

// File: tb/tb_clt_gauss_acc.sv
// -----------------------------------------------------------------------------
// tb_clt_gauss_acc
// Directed, self-checking bench for clt_gauss_acc (UW=16, LOG2_N=2, OW=18).
// A small generator model presents words from a table and advances one entry
// on every rising edge where uni_req is high.
// -----------------------------------------------------------------------------
module tb_clt_gauss_acc;

  localparam int UW     = 16;
  localparam int LOG2_N = 2;
  localparam int OW     = UW + LOG2_N;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          uni_req;
  logic [31:0]   uni_data;
  logic          uni_valid;
  logic [OW-1:0] g_data;
  logic          g_valid;
  logic          g_ready;
  logic          busy;
`ifdef CLT_GAUSS_STATS_EN
  logic [31:0]   stat_cnt;
`endif

  logic [31:0] words [0:63];
  int          gen_idx;
  int          adv_cnt;
  bit          gen_primed;
  int          pass_cnt;
  int          total_cnt;

  always #5 clk = ~clk;

  clt_gauss_acc #(.UW(UW), .LOG2_N(LOG2_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .uni_req   (uni_req),
    .uni_data  (uni_data),
    .uni_valid (uni_valid),
    .g_data    (g_data),
    .g_valid   (g_valid),
    .g_ready   (g_ready),
    .busy      (busy)
`ifdef CLT_GAUSS_STATS_EN
    ,
    .stat_cnt  (stat_cnt)
`endif
  );

  // One clock: generator model advances if uni_req was high at the edge.
  task automatic tick();
    bit req;
    req = uni_req;
    @(posedge clk);
    #1;
    if (req) begin
      gen_idx    = (gen_idx + 1) % 64;
      adv_cnt    = adv_cnt + 1;
      gen_primed = 1'b1;
    end
    uni_data  = words[gen_idx];
    uni_valid = gen_primed;
  endtask

  task automatic fill(input logic [31:0] w);
    for (int i = 0; i < 64; i++) words[i] = w;
    gen_idx   = 0;
    adv_cnt   = 0;
    uni_data  = words[0];
    uni_valid = gen_primed;
  endtask

  task automatic wait_gvalid(input int max_cyc, output bit ok);
    for (int i = 0; i < max_cyc; i++) begin
      if (g_valid) break;
      tick();
    end
    ok = g_valid;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total_cnt++; if (uni_req !== 1'b0) $display("FAIL reset_uni_req got %b want 0", uni_req); else pass_cnt++;
    total_cnt++; if (g_valid !== 1'b0) $display("FAIL reset_g_valid got %b want 0", g_valid); else pass_cnt++;
    total_cnt++; if (g_data !== 18'h0) $display("FAIL reset_g_data got %h want 00000", g_data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_midscale();
    bit ok;
    gen_primed = 1'b1;
    fill(32'h8000_0000);
    en = 1'b1;
    g_ready = 1'b0;
    wait_gvalid(30, ok);
    total_cnt++; if (!ok) $display("FAIL mid_timeout got g_valid=%b want 1", g_valid); else pass_cnt++;
    total_cnt++; if (g_data !== 18'h00000) $display("FAIL mid_g_data got %h want 00000", g_data); else pass_cnt++;
    total_cnt++; if (adv_cnt !== 4) $display("FAIL mid_accepts got %0d want 4", adv_cnt); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy_out got %b want 1", busy); else pass_cnt++;
    en = 1'b0;
    g_ready = 1'b1;
    tick();
    g_ready = 1'b0;
    total_cnt++; if (g_valid !== 1'b0) $display("FAIL mid_g_valid_drop got %b want 0", g_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL mid_idle_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_extremes();
    logic [31:0]   pat [0:1];
    logic [OW-1:0] exp [0:1];
    bit ok;
    pat[0] = 32'hFFFF_FFFF; exp[0] = 18'h1FFFC;
    pat[1] = 32'h0000_0000; exp[1] = 18'h20000;
    for (int k = 0; k < 2; k++) begin
      fill(pat[k]);
      en = 1'b1;
      wait_gvalid(30, ok);
      en = 1'b0;
      total_cnt++; if (!ok) $display("FAIL ext_timeout[%0d] got g_valid=%b want 1", k, g_valid); else pass_cnt++;
      total_cnt++; if (g_data !== exp[k]) $display("FAIL ext_g_data[%0d] got %h want %h", k, g_data, exp[k]); else pass_cnt++;
      g_ready = 1'b1;
      tick();
      g_ready = 1'b0;
    end
  endtask

  task automatic test_priming();
    bit ok;
    pulse_reset();
    gen_primed = 1'b0;
    fill(32'h0000_0000);
    words[0] = 32'hDEAD_0000;
    for (int k = 1; k <= 4; k++) words[k] = 32'(k) << 16;
    uni_data = words[0];
    en = 1'b1;
    wait_gvalid(30, ok);
    en = 1'b0;
    total_cnt++; if (!ok) $display("FAIL prime_timeout got g_valid=%b want 1", g_valid); else pass_cnt++;
    total_cnt++; if (g_data !== 18'h2000A) $display("FAIL prime_g_data got %h want 2000a", g_data); else pass_cnt++;
    total_cnt++; if (adv_cnt !== 5) $display("FAIL prime_requests got %0d want 5", adv_cnt); else pass_cnt++;
    g_ready = 1'b1;
    tick();
    g_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int adv0;
    int bad;
    logic [OW-1:0] d0;
    fill(32'h1234_0000);
    en = 1'b1;
    wait_gvalid(30, ok);
    en = 1'b0;
    adv0 = adv_cnt;
    d0   = g_data;
    bad  = 0;
    total_cnt++; if (d0 !== 18'h248D0) $display("FAIL bp_g_data got %h want 248d0", d0); else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (g_data !== d0 || uni_req !== 1'b0 || g_valid !== 1'b1) bad++;
    end
    total_cnt++; if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad); else pass_cnt++;
    total_cnt++; if (adv_cnt !== adv0) $display("FAIL bp_no_advance got %0d want %0d", adv_cnt, adv0); else pass_cnt++;
    g_ready = 1'b1;
    tick();
    g_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    fill(32'hFFFF_0000);
    for (int k = 0; k < 4; k++) words[2 + k] = 32'(5 + k) << 16;
    en = 1'b1;
    tick();
    tick();
    tick();
    total_cnt++; if (adv_cnt !== 2) $display("FAIL rm_pre_accepts got %0d want 2", adv_cnt); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (g_data !== 18'h0) $display("FAIL rm_g_data got %h want 00000", g_data); else pass_cnt++;
    total_cnt++; if ({uni_req, g_valid, busy} !== 3'b000) $display("FAIL rm_ctrl got %b want 000", {uni_req, g_valid, busy}); else pass_cnt++;
    tick();
    reset = 1'b0;
    adv_cnt = 0;
    wait_gvalid(30, ok);
    en = 1'b0;
    total_cnt++; if (!ok) $display("FAIL rm_timeout got g_valid=%b want 1", g_valid); else pass_cnt++;
    total_cnt++; if (g_data !== 18'h2001A) $display("FAIL rm_fresh_sum got %h want 2001a", g_data); else pass_cnt++;
    total_cnt++; if (adv_cnt !== 4) $display("FAIL rm_fresh_accepts got %0d want 4", adv_cnt); else pass_cnt++;
    g_ready = 1'b1;
    tick();
    g_ready = 1'b0;
  endtask

  task automatic test_drop_en();
    bit ok;
    fill(32'h0001_0000);
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_gvalid(30, ok);
    total_cnt++; if (!ok) $display("FAIL drop_timeout got g_valid=%b want 1", g_valid); else pass_cnt++;
    total_cnt++; if (g_data !== 18'h20004) $display("FAIL drop_g_data got %h want 20004", g_data); else pass_cnt++;
    g_ready = 1'b1;
    tick();
    g_ready = 1'b0;
    tick();
    total_cnt++; if ({uni_req, g_valid, busy} !== 3'b000) $display("FAIL drop_idle got %b want 000", {uni_req, g_valid, busy}); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    fill(32'h0002_0000);
    en = 1'b1;
    g_ready = 1'b1;
    wait_gvalid(30, ok);
    total_cnt++; if (g_data !== 18'h20008) $display("FAIL b2b_first got %h want 20008", g_data); else pass_cnt++;
    n = 0;
    tick();
    n = 1;
    while (!g_valid && n < 20) begin
      tick();
      n++;
    end
    total_cnt++; if (n !== 5) $display("FAIL b2b_period got %0d want 5", n); else pass_cnt++;
    total_cnt++; if (g_data !== 18'h20008) $display("FAIL b2b_second got %h want 20008", g_data); else pass_cnt++;
    en = 1'b0;
    tick();
    g_ready = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_idle got %b want 0", busy); else pass_cnt++;
  endtask

`ifdef CLT_GAUSS_STATS_EN
  task automatic test_stats();
    bit ok;
    pulse_reset();
    fill(32'h0003_0000);
    total_cnt++; if (stat_cnt !== 32'd0) $display("FAIL stat_reset got %h want 0", stat_cnt); else pass_cnt++;
    en = 1'b1;
    g_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_gvalid(30, ok);
      if (k == 2) en = 1'b0;
      tick();
    end
    g_ready = 1'b0;
    total_cnt++; if (stat_cnt !== 32'd3) $display("FAIL stat_three got %0d want 3", stat_cnt); else pass_cnt++;
    dut.stat_cnt_q = 32'hFFFF_FFFF;
    en = 1'b1;
    wait_gvalid(30, ok);
    en = 1'b0;
    g_ready = 1'b1;
    tick();
    g_ready = 1'b0;
    total_cnt++; if (stat_cnt !== 32'd0) $display("FAIL stat_wrap got %h want 0", stat_cnt); else pass_cnt++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    reset      = 1'b1;
    en         = 1'b0;
    g_ready    = 1'b0;
    gen_primed = 1'b1;
    fill(32'h0000_0000);
    test_reset();
    test_midscale();
    test_extremes();
    test_priming();
    test_backpressure();
    test_reset_mid();
    test_drop_en();
    test_back_to_back();
`ifdef CLT_GAUSS_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
